if_queue: RTL
=============

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch entries; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 3, width of count, equal to log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  discard all held entries (taken jump or branch redirect).
REQ-006 in_valid  input  1  fetch stage presents an entry.
REQ-007 in_pc  input  32  address of the presented instruction.
REQ-008 in_inst  input  32  presented instruction word.
REQ-009 in_ready  output  1  queue accepts an entry this cycle.
REQ-010 out_valid  output  1  head entry is available to decode.
REQ-011 out_pc  output  32  head entry address.
REQ-012 out_inst  output  32  head entry instruction.
REQ-013 out_ready  input  1  decode consumes the head this cycle; low acts as hold.
REQ-014 count  output  CNT_W  number of occupied entries.

Function
REQ-015 The queue SHALL be FIFO-ordered storage of {pc, inst} pairs between the PC/fetch stage and decode.
REQ-016 Push: in_valid and in_ready at a rising edge SHALL write the entry at the write pointer.
REQ-017 Pop: out_valid and out_ready at a rising edge SHALL advance the read pointer.
REQ-018 in_ready SHALL be (count < DEPTH) and not flush, with no dependence on out_ready; when full, a same-cycle pop does not enable a push.
REQ-019 out_valid SHALL be (count != 0).
REQ-020 While out_valid is low, out_pc SHALL be 0 and out_inst SHALL be NOP 32'h00000013.
REQ-021 Write and read pointers SHALL wrap modulo DEPTH.
REQ-022 A simultaneous push and pop SHALL leave count unchanged.
REQ-023 count SHALL never exceed DEPTH and never go below 0; a push when full or a pop when empty SHALL be ignored.
REQ-024 flush SHALL have priority over push and pop: at the next edge both pointers and count clear to 0, and the entry presented that cycle is dropped.
REQ-025 Latency: without bypass, an entry pushed into an empty queue SHALL appear at the outputs one cycle after the push edge.

Reset
REQ-026 rst high SHALL asynchronously clear both pointers and count to 0.
REQ-027 While rst is high, outputs SHALL be: out_valid 0, out_pc 0, out_inst NOP, in_ready 0, count 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries, with no partial pop or push.
REQ-029 Storage contents need not be reset.

Configuration
REQ-030 Macro IF_QUEUE_BYPASS_EN, when defined, SHALL enable zero-latency bypass. When the queue is empty, in_valid is high and flush is low:
- out_valid SHALL be 1 in the same cycle;
- out_pc and out_inst SHALL equal in_pc and in_inst;
- if out_ready is also high, the entry SHALL be consumed without being written, and count stays 0.
REQ-031 Without IF_QUEUE_BYPASS_EN, no combinational path SHALL exist from in_* to out_*.

Structure
REQ-032 The shared defines file SHALL hold the 32-bit address and instruction width macros, the NOP encoding, and the reset-polarity macro.
REQ-033 Storage SHALL be a single sub-module, if_queue_ram (DEPTH x 64, one write port, one asynchronous read port); pointer and count logic SHALL reside in if_queue.

Verification
REQ-034 Reset release, no input -> out_valid 0, out_inst 32'h00000013, count 0, in_ready 1.
REQ-035 Push pc 0x0, 0x4, 0x8, 0xC with out_ready 0 -> count 4, in_ready 0; fifth push at 0x10 ignored; with out_ready 1, pops return 0x0, 0x4, 0x8, 0xC in order.
REQ-036 Queue holds 2 entries; push and pop in the same cycle for 6 cycles -> count stays 2, output order preserved across pointer wrap.
REQ-037 Queue holds 3 entries; flush=1 together with a push of 0x100 -> next cycle count 0, out_valid 0; a push of 0x200 the following cycle appears as the head.
REQ-038 rst pulsed asynchronously between edges with 2 entries held -> out_valid drops immediately, count 0.
REQ-039 With IF_QUEUE_BYPASS_EN, queue empty, push 0x40/0x00100093 with out_ready 1 -> out_pc 0x40 the same cycle, count remains 0; the same stimulus without the macro -> output appears the next cycle, count 1 then 0.

Source files
------------

// File: rtl/if_queue_pkg.sv
// Shared widths, NOP encoding and reset polarity for the instruction-fetch queue.
package if_queue_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int ENTRY_W = ADDR_W + INST_W;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    // Reset is asynchronous and active-high throughout this block.
    localparam bit RST_ACTIVE_HIGH = 1'b1;
endpackage

// File: rtl/if_queue_ram.sv
// Entry storage for if_queue: one synchronous write port, one asynchronous read port.
module if_queue_ram
    import if_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);
    logic [ENTRY_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; count qualifies every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/if_queue.sv
// Fetch-to-decode FIFO of {pc, inst} pairs with flush.
// Define IF_QUEUE_BYPASS_EN to forward an entry straight to decode when the queue is empty.
module if_queue
    import if_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] rd_data;
    logic               empty;
    logic               bypass;
    logic               bypass_take;
    logic               do_push;
    logic               do_pop;

    assign empty = (count == '0);

`ifdef IF_QUEUE_BYPASS_EN
    assign bypass = !rst && empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif
    assign bypass_take = bypass && out_ready;

    // in_ready ignores out_ready, so a full queue never accepts even with a same-cycle pop.
    assign in_ready = !rst && (count < CNT_W'(DEPTH)) && !flush;
    assign do_push  = in_valid && in_ready && !bypass_take;
    assign do_pop   = !empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    if_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_push && !flush),
        .wr_addr (wr_ptr),
        .wr_data ({in_pc, in_inst}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = NOP_INST;
        if (!empty) begin
            out_valid = 1'b1;
            out_pc    = rd_data[ENTRY_W-1:INST_W];
            out_inst  = rd_data[INST_W-1:0];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end
endmodule
